// File: rtl/cipher_sequencer_pkg.sv
// Shared types and default constants for the stream-cipher sequencer.
package cipher_sequencer_pkg;

  // State of the upstream interface FSM, as seen by the sequencer.
  typedef enum logic [1:0] {
    I_IDLE       = 2'd0,
    I_PROCESSING = 2'd1,
    I_DONE       = 2'd2
  } interface_state_t;

  // Sequencer FSM states.
  typedef enum logic [2:0] {
    SQ_UNKEYED = 3'd0,
    SQ_LOAD    = 3'd1,
    SQ_WARMUP  = 3'd2,
    SQ_IDLE    = 3'd3,
    SQ_STEP    = 3'd4,
    SQ_CAPTURE = 3'd5,
    SQ_HOLD    = 3'd6
  } sequencer_state_t;

  localparam int DEFAULT_WARMUP_CYCLES  = 32;
  localparam int DEFAULT_STEPS_PER_WORD = 8;

  // Larger of two integers; used to size the shared step counter.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/cipher_sequencer_step_counter.sv
// Clearable up-counter with terminal compare, shared by warm-up and word bursts.
module step_counter #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] term,
  output logic         done
);

  logic [W-1:0] r_count;

  // Clear has priority over count so the counter never runs past the terminal.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (en) begin
      r_count <= r_count + 1'b1;
    end
  end

  // Terminal reached: this is the last step of the current burst.
  always_comb begin
    done = (r_count == term);
  end

endmodule

// File: rtl/cipher_sequencer.sv
// Sequencer for the keystream core: key load, warm-up, per-word step bursts,
// word capture and the ready handshake back to the interface FSM.
// Handshake: output_is_ready stays high from the cycle after word_capture until
// interface_state_in is seen outside I_PROCESSING; it drops the following cycle.
module cipher_sequencer
  import cipher_sequencer_pkg::*;
#(
  parameter int WARMUP_CYCLES  = DEFAULT_WARMUP_CYCLES,
  parameter int STEPS_PER_WORD = DEFAULT_STEPS_PER_WORD,
  localparam int CNT_W = $clog2(max_int(WARMUP_CYCLES, STEPS_PER_WORD) + 1)
) (
  input  logic             clk,
  input  logic             nrst,
  input  interface_state_t interface_state_in,
  input  logic             key_load_req,
  output logic             core_load,
  output logic             core_step,
  output logic             word_capture,
  output logic             output_is_ready,
  output logic             keyed,
  output logic             busy,
  output sequencer_state_t dbg_state
);

  localparam logic [CNT_W-1:0] WARM_TERM = CNT_W'(WARMUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] STEP_TERM = CNT_W'(STEPS_PER_WORD - 1);

  sequencer_state_t r_state;
  sequencer_state_t w_next;
  logic             r_rekey_pending;
  logic             w_in_burst;
  logic             w_cnt_clr;
  logic [CNT_W-1:0] w_cnt_term;
  logic             w_cnt_done;
  logic             w_processing;

  assign w_processing = (interface_state_in == I_PROCESSING);
  assign w_in_burst   = (r_state == SQ_WARMUP) || (r_state == SQ_STEP);
  // Cleared outside bursts and on the terminal step, so every burst starts at 0.
  assign w_cnt_clr    = !w_in_burst || w_cnt_done;
  assign w_cnt_term   = (r_state == SQ_WARMUP) ? WARM_TERM : STEP_TERM;

  step_counter #(
    .W(CNT_W)
  ) u_step_counter (
    .clk  (clk),
    .nrst (nrst),
    .clr  (w_cnt_clr),
    .en   (w_in_burst),
    .term (w_cnt_term),
    .done (w_cnt_done)
  );

  // State register.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state <= SQ_UNKEYED;
    end else begin
      r_state <= w_next;
    end
  end

  // Remember a rekey request that arrives while a word is in flight.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_rekey_pending <= 1'b0;
    end else if (r_state == SQ_LOAD) begin
      r_rekey_pending <= 1'b0;
    end else if (key_load_req &&
                 ((r_state == SQ_STEP) || (r_state == SQ_CAPTURE) ||
                  (r_state == SQ_HOLD))) begin
      r_rekey_pending <= 1'b1;
    end
  end

  // Next-state decode.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      SQ_UNKEYED: if (key_load_req) w_next = SQ_LOAD;
      SQ_LOAD:    w_next = SQ_WARMUP;
      SQ_WARMUP:  if (w_cnt_done) w_next = SQ_IDLE;
      SQ_IDLE: begin
        if (key_load_req || r_rekey_pending) begin
          w_next = SQ_LOAD;
        end else if (w_processing) begin
          w_next = SQ_STEP;
        end
      end
      SQ_STEP:    if (w_cnt_done) w_next = SQ_CAPTURE;
      SQ_CAPTURE: w_next = SQ_HOLD;
      SQ_HOLD:    if (!w_processing) w_next = SQ_IDLE;
      default:    w_next = SQ_UNKEYED;
    endcase
  end

  // Moore output decode from the registered state.
  always_comb begin
    core_load       = (r_state == SQ_LOAD);
    core_step       = w_in_burst;
    word_capture    = (r_state == SQ_CAPTURE);
    output_is_ready = (r_state == SQ_HOLD);
    keyed           = (r_state == SQ_IDLE) || (r_state == SQ_STEP) ||
                      (r_state == SQ_CAPTURE) || (r_state == SQ_HOLD);
    busy            = (r_state == SQ_LOAD) || (r_state == SQ_WARMUP) ||
                      (r_state == SQ_STEP) || (r_state == SQ_CAPTURE);
    dbg_state       = r_state;
  end

endmodule
